// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle/event counters with a cycle budget and a frozen
// snapshot streamed over valid/ready. Define PERF_SATURATE_EN for saturating counters + ovf_o.
module pipe_perf_monitor #(
  parameter int unsigned NUM_EVT    = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned MAX_CYCLES = 30,
  localparam int unsigned DATA_W    = (CNT_W > PC_W) ? CNT_W : PC_W,
  localparam int unsigned IDX_W     = $clog2(NUM_EVT + 2)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               dump_req_i,
  input  logic               dump_ready_i,
  output logic               dump_valid_o,
  output logic [DATA_W-1:0]  dump_data_o,
  output logic [IDX_W-1:0]   dump_idx_o,
  output logic               dump_last_o,
  output logic               halt_o,
  output logic [CNT_W-1:0]   cycle_o
`ifdef PERF_SATURATE_EN
  ,
  output logic [NUM_EVT:0]   ovf_o
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} cnt_state_e;
  typedef enum logic {StDIdle, StDSend} dump_state_e;

  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(NUM_EVT + 1);
  localparam logic [CNT_W-1:0] BudgetLast = CNT_W'(MAX_CYCLES - 1);

  cnt_state_e                      cnt_state_q;
  dump_state_e                     dump_state_q;
  logic                            halt_q;
  logic [CNT_W-1:0]                cycle_cnt_q, cycle_inc;
  logic [NUM_EVT-1:0][CNT_W-1:0]   evt_cnt_q, evt_inc;
  logic [PC_W-1:0]                 last_pc_q;
  logic [CNT_W-1:0]                snap_cycle_q;
  logic [NUM_EVT-1:0][CNT_W-1:0]   snap_evt_q;
  logic [PC_W-1:0]                 snap_pc_q;
  logic [IDX_W-1:0]                dump_idx_q;
  logic                            budget_hit;
`ifdef PERF_SATURATE_EN
  logic [NUM_EVT:0]                ovf_q, ovf_hit;
`endif

  // Incremented values used on a counting edge
  always_comb begin
    evt_inc = '0;
`ifdef PERF_SATURATE_EN
    ovf_hit    = '0;
    ovf_hit[0] = &cycle_cnt_q;
    cycle_inc  = ovf_hit[0] ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    for (int k = 0; k < NUM_EVT; k++) begin
      ovf_hit[k+1] = evt_i[k] & (&evt_cnt_q[k]);
      evt_inc[k]   = (evt_i[k] && !(&evt_cnt_q[k])) ? evt_cnt_q[k] + CNT_W'(1) : evt_cnt_q[k];
    end
`else
    cycle_inc = cycle_cnt_q + CNT_W'(1);
    for (int k = 0; k < NUM_EVT; k++) begin
      evt_inc[k] = evt_cnt_q[k] + CNT_W'(evt_i[k]);
    end
`endif
  end

  assign budget_hit = (MAX_CYCLES != 0) && (cycle_cnt_q == BudgetLast);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_state_q <= StIdle;
      halt_q      <= 1'b0;
      cycle_cnt_q <= '0;
      evt_cnt_q   <= '0;
      last_pc_q   <= '0;
`ifdef PERF_SATURATE_EN
      ovf_q       <= '0;
`endif
    end else if (clr_i) begin
      cnt_state_q <= StIdle;
      halt_q      <= 1'b0;
      cycle_cnt_q <= '0;
      evt_cnt_q   <= '0;
      last_pc_q   <= '0;
`ifdef PERF_SATURATE_EN
      ovf_q       <= '0;
`endif
    end else begin
      case (cnt_state_q)
        StIdle: begin
          if (start_i) cnt_state_q <= StRun;
        end
        StRun: begin
          if (start_i) begin
            cycle_cnt_q <= cycle_inc;
            evt_cnt_q   <= evt_inc;
            last_pc_q   <= pc_i;
`ifdef PERF_SATURATE_EN
            ovf_q       <= ovf_q | ovf_hit;
`endif
            if (budget_hit) begin
              cnt_state_q <= StHalt;
              halt_q      <= 1'b1;
            end
          end
        end
        StHalt: begin
        end
        default: begin
          cnt_state_q <= StIdle;
          halt_q      <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot takes pre-edge counter values; clr_i deliberately does not touch the dump path
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dump_state_q <= StDIdle;
      dump_idx_q   <= '0;
      snap_cycle_q <= '0;
      snap_evt_q   <= '0;
      snap_pc_q    <= '0;
    end else begin
      case (dump_state_q)
        StDIdle: begin
          if (dump_req_i) begin
            snap_cycle_q <= cycle_cnt_q;
            snap_evt_q   <= evt_cnt_q;
            snap_pc_q    <= last_pc_q;
            dump_idx_q   <= '0;
            dump_state_q <= StDSend;
          end
        end
        StDSend: begin
          if (dump_ready_i) begin
            if (dump_idx_q == LastIdx) begin
              dump_idx_q   <= '0;
              dump_state_q <= StDIdle;
            end else begin
              dump_idx_q <= dump_idx_q + IDX_W'(1);
            end
          end
        end
        default: dump_state_q <= StDIdle;
      endcase
    end
  end

  assign dump_valid_o = (dump_state_q == StDSend);
  assign dump_idx_o   = dump_idx_q;
  assign dump_last_o  = dump_valid_o && (dump_idx_q == LastIdx);

  always_comb begin
    dump_data_o = '0;
    if (dump_valid_o) begin
      if (dump_idx_q == '0) begin
        dump_data_o = DATA_W'(snap_cycle_q);
      end else if (dump_idx_q == LastIdx) begin
        dump_data_o = DATA_W'(snap_pc_q);
      end
      for (int k = 0; k < NUM_EVT; k++) begin
        if (dump_idx_q == IDX_W'(k + 1)) dump_data_o = DATA_W'(snap_evt_q[k]);
      end
    end
  end

  assign halt_o  = halt_q;
  assign cycle_o = cycle_cnt_q;
`ifdef PERF_SATURATE_EN
  assign ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed phases plus random stimulus, all checked against a
// behavioural model of counts and a queue of expected stream words.
module tb_pipe_perf_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, clr, req, ready;
  logic [1:0]  evt;
  logic [31:0] pc;
  logic        valid, last, halt;
  logic [31:0] data, cyc;
  logic [1:0]  idx;

  logic        start2, req2, ready2;
  logic [1:0]  evt2;
  logic [31:0] pc2;
  logic        valid2, last2, halt2;
  logic [31:0] data2;
  logic [1:0]  idx2;
  logic [3:0]  cyc2;
`ifdef PERF_SATURATE_EN
  logic [2:0]  ovf, ovf2;
`endif

  pipe_perf_monitor dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .clr_i       (clr),
    .evt_i       (evt),
    .pc_i        (pc),
    .dump_req_i  (req),
    .dump_ready_i(ready),
    .dump_valid_o(valid),
    .dump_data_o (data),
    .dump_idx_o  (idx),
    .dump_last_o (last),
    .halt_o      (halt),
    .cycle_o     (cyc)
`ifdef PERF_SATURATE_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  pipe_perf_monitor #(
    .CNT_W     (4),
    .MAX_CYCLES(0)
  ) dut_small (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start2),
    .clr_i       (1'b0),
    .evt_i       (evt2),
    .pc_i        (pc2),
    .dump_req_i  (req2),
    .dump_ready_i(ready2),
    .dump_valid_o(valid2),
    .dump_data_o (data2),
    .dump_idx_o  (idx2),
    .dump_last_o (last2),
    .halt_o      (halt2),
    .cycle_o     (cyc2)
`ifdef PERF_SATURATE_EN
    ,
    .ovf_o       (ovf2)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 = idle, 1 = running, 2 = budget spent
  int          m_mode;
  logic [31:0] m_cyc, m_pc;
  logic [31:0] m_evt [2];
  logic [31:0] m_q [$];
  bit          bp_count = 0;
  int          xfers    = 0;

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; m_cyc = 0; m_pc = 0; m_evt[0] = 0; m_evt[1] = 0;
      m_q.delete();
    end else begin
      if (m_q.size() == 0) begin
        if (req) begin
          m_q.push_back(m_cyc);
          m_q.push_back(m_evt[0]);
          m_q.push_back(m_evt[1]);
          m_q.push_back(m_pc);
        end
      end else if (ready) begin
        void'(m_q.pop_front());
      end
      if (clr) begin
        m_mode = 0; m_cyc = 0; m_pc = 0; m_evt[0] = 0; m_evt[1] = 0;
      end else if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 1 && start) begin
        m_cyc    = m_cyc + 1;
        m_evt[0] = m_evt[0] + 32'(evt[0]);
        m_evt[1] = m_evt[1] + 32'(evt[1]);
        m_pc     = pc;
        if (m_cyc == 30) m_mode = 2;
      end
    end
  endtask

  task automatic tick();
    if (bp_count && valid && ready) begin
      check("bp_order", idx, xfers);
      xfers++;
    end
    @(posedge clk);
    model_edge();
    #1;
    check("cycle_o", cyc, m_cyc);
    check("halt_o", halt, m_mode == 2);
    check("dump_valid_o", valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("dump_data_o", data, m_q[0]);
      check("dump_idx_o", idx, 4 - m_q.size());
      check("dump_last_o", last, m_q.size() == 1);
    end else begin
      check("dump_last_idle", last, 1'b0);
    end
  endtask

  logic [31:0] last_pc;
  logic [31:0] exp_c, exp_e;

  initial begin
    rst_n = 0; start = 0; clr = 0; req = 0; ready = 0; evt = 0; pc = 0;
    start2 = 0; req2 = 0; ready2 = 1; evt2 = 0; pc2 = 0;

    tick();
    tick();
    check("rst_cycle", cyc, 0);
    check("rst_halt", halt, 0);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);

    // Budget run with scheduled events
    rst_n = 1; start = 1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      evt     = {(c >= 7 && c <= 9), (c <= 7)};
      pc      = $urandom;
      last_pc = pc;
      tick();
      check("budget_cnt", cyc, c);
    end
    evt = 0;
    check("halt_at_budget", halt, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("budget_hold", cyc, 30);
    end

    ready = 1; req = 1;
    tick();
    req = 0;
    check("dump0", data, 30);
    check("dump0_idx", idx, 0);
    tick();
    check("dump1", data, 7);
    tick();
    check("dump2", data, 3);
    tick();
    check("dump3", data, last_pc);
    check("dump3_last", last, 1);
    tick();
    check("dump_done", valid, 0);

    // Backpressure with a redundant request mid-stream
    req = 1;
    tick();
    req = 0; bp_count = 1; xfers = 0;
    for (int i = 0; i < 40; i++) begin
      ready = (i % 3 == 0);
      req   = (i == 2);
      tick();
      if (!valid) break;
    end
    bp_count = 0; req = 0;
    check("bp_xfers", xfers, 4);

    // Clear from halt, resume, pause
    ready = 1; clr = 1;
    tick();
    clr = 0;
    check("clr_cycle", cyc, 0);
    check("clr_halt", halt, 0);
    start = 0;
    tick();
    check("clr_idle", cyc, 0);
    start = 1;
    tick();
    check("resume_first_edge", cyc, 0);
    evt = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause", cyc, 5);
    end

    // Snapshot isolation
    start = 1; evt = 2'b01; req = 1;
    tick();
    req = 0; evt = 0;
    check("iso_live_cycle", cyc, 6);
    check("iso_snap_cycle", data, 5);
    tick();
    check("iso_snap_evt0", data, 5);
    tick(); tick(); tick();
    start = 0; req = 1;
    tick();
    req = 0;
    tick();
    check("iso_live_evt0", data, 6);
    tick(); tick(); tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 3) != 0);
      evt   = 2'($urandom);
      pc    = $urandom;
      req   = ($urandom_range(0, 7) == 0);
      ready = 1'($urandom);
      tick();
    end
    rst_n = 1; clr = 0; start = 0; req = 0; ready = 1; evt = 0;
    for (int i = 0; i < 6; i++) tick();

    // Narrow-counter overflow on the second instance
    start2 = 1; evt2 = 2'b01;
    for (int i = 0; i < 21; i++) tick();
    start2 = 0; evt2 = 0;
`ifdef PERF_SATURATE_EN
    exp_c = 15; exp_e = 15;
    check("sat_ovf", ovf2, 3'b011);
    check("main_ovf", ovf, 3'b000);
`else
    exp_c = 4; exp_e = 4;
`endif
    check("small_cycle_live", cyc2, exp_c);
    req2 = 1;
    tick();
    req2 = 0;
    check("small_cycle", data2, exp_c);
    tick();
    check("small_evt0", data2, exp_e);
    tick();
    check("small_evt1", data2, 0);
    tick(); tick();
    check("small_done", valid2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
